// File: rtl/conv_pkg.sv
// Shared engine handshake codes and sequencer state encoding for the
// convolution layer scheduler and the engine control FSM.
package conv_pkg;

    localparam logic [3:0] CTRL_NOP  = 4'b0000;
    localparam logic [3:0] CTRL_PARA = 4'b0001;
    localparam logic [3:0] CTRL_COMP = 4'b0010;
    localparam logic [3:0] CTRL_ACK  = 4'b1111;

    localparam logic [3:0] ST_IDLE = 4'b0000;
    localparam logic [3:0] ST_PARA = 4'b0001;
    localparam logic [3:0] ST_COMP = 4'b0010;
    localparam logic [3:0] ST_IRQ  = 4'b1111;

    localparam logic [1:0] PHASE_NONE = 2'b00;
    localparam logic [1:0] PHASE_PARA = 2'b01;
    localparam logic [1:0] PHASE_COMP = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_P_REQ  = 4'd1,
        S_P_WAIT = 4'd2,
        S_P_ACK  = 4'd3,
        S_C_REQ  = 4'd4,
        S_C_WAIT = 4'd5,
        S_C_ACK  = 4'd6,
        S_FINISH = 4'd7,
        S_ERR    = 4'd8
    } seq_state_t;

    // States in which the engine owes us a response and the watchdog runs.
    function automatic logic wdog_active(input seq_state_t s);
        return s inside {S_P_REQ, S_P_WAIT, S_P_ACK, S_C_REQ, S_C_WAIT, S_C_ACK};
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Per-state stall counter: cleared on request, counts while enabled and
// holds at all-ones, where it reports saturation.
module seq_watchdog #(
    parameter int unsigned WDOG_W = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic sat
);

    logic [WDOG_W-1:0] cnt;

    assign sat = (cnt == '1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !sat) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/conv_layer_sequencer.sv
// Runs a parameter-load then compute handshake with the convolution engine
// for each of N layers, acknowledging every engine interrupt.
module conv_layer_sequencer
    import conv_pkg::*;
#(
    parameter int unsigned LAYER_W = 6,
    parameter int unsigned WDOG_W  = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LAYER_W-1:0] layer_num,
    input  logic [3:0]         eng_state,
    output logic [3:0]         control,
    output logic               busy,
    output logic [LAYER_W-1:0] layer_idx,
    output logic [1:0]         phase,
    output logic               done,
    output logic               timeout_err
);

    localparam logic [LAYER_W-1:0] ONE = LAYER_W'(1);

    seq_state_t         state;
    seq_state_t         state_nxt;
    logic [LAYER_W-1:0] num_q;
    logic               wd_clr;
    logic               wd_en;
    logic               wd_sat;

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (start) state_nxt = (layer_num == '0) ? S_FINISH : S_P_REQ;
            S_P_REQ:  if (eng_state == ST_PARA) state_nxt = S_P_WAIT;
            S_P_WAIT: if (eng_state == ST_IRQ)  state_nxt = S_P_ACK;
            S_P_ACK:  if (eng_state == ST_IDLE) state_nxt = S_C_REQ;
            S_C_REQ:  if (eng_state == ST_COMP) state_nxt = S_C_WAIT;
            S_C_WAIT: if (eng_state == ST_IRQ)  state_nxt = S_C_ACK;
            S_C_ACK:
                if (eng_state == ST_IDLE)
                    state_nxt = (layer_idx == num_q - ONE) ? S_FINISH : S_P_REQ;
            S_FINISH: state_nxt = S_IDLE;
            S_ERR:    state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        // A stall abort wins over any handshake completing in the same cycle.
        if (wdog_active(state) && wd_sat) state_nxt = S_ERR;
    end

    assign wd_clr = (state_nxt != state) || (state == S_IDLE);
    assign wd_en  = wdog_active(state);

    seq_watchdog #(
        .WDOG_W(WDOG_W)
    ) u_wdog (
        .clk(clk),
        .rst(rst),
        .clr(wd_clr),
        .en (wd_en),
        .sat(wd_sat)
    );

    // Outputs are decoded from the current state, so they trail it by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            num_q       <= '0;
            control     <= CTRL_NOP;
            busy        <= 1'b0;
            layer_idx   <= '0;
            phase       <= PHASE_NONE;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    control <= CTRL_NOP;
                    phase   <= PHASE_NONE;
                    if (start) begin
                        busy        <= 1'b1;
                        num_q       <= layer_num;
                        layer_idx   <= '0;
                        timeout_err <= 1'b0;
                    end
                end
                S_P_REQ:  begin control <= CTRL_PARA; phase <= PHASE_PARA; end
                S_P_WAIT: begin control <= CTRL_NOP;  phase <= PHASE_PARA; end
                S_P_ACK:  begin control <= CTRL_ACK;  phase <= PHASE_PARA; end
                S_C_REQ:  begin control <= CTRL_COMP; phase <= PHASE_COMP; end
                S_C_WAIT: begin control <= CTRL_NOP;  phase <= PHASE_COMP; end
                S_C_ACK: begin
                    control <= CTRL_ACK;
                    phase   <= PHASE_COMP;
                    if (state_nxt == S_P_REQ) layer_idx <= layer_idx + ONE;
                end
                S_FINISH: begin
                    control <= CTRL_NOP;
                    phase   <= PHASE_NONE;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                end
                S_ERR: begin
                    control     <= CTRL_NOP;
                    phase       <= PHASE_NONE;
                    timeout_err <= 1'b1;
                    busy        <= 1'b0;
                end
                default: begin
                    control <= CTRL_NOP;
                    phase   <= PHASE_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Scoreboard bench for conv_layer_sequencer with a reactive engine model.
module tb_conv_layer_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [5:0] layer_num;
    logic [3:0] eng_state;
    logic [3:0] control;
    logic       busy;
    logic [5:0] layer_idx;
    logic [1:0] phase;
    logic       done;
    logic       timeout_err;

    conv_layer_sequencer #(
        .LAYER_W(6),
        .WDOG_W (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .layer_num  (layer_num),
        .eng_state  (eng_state),
        .control    (control),
        .busy       (busy),
        .layer_idx  (layer_idx),
        .phase      (phase),
        .done       (done),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name, input logic [31:0] act);
        vectors++;
        miscompares++;
        $display("FAIL %s: actual %0h required none", name, act);
    endtask

    // Engine model: internal state reported one cycle late; 5 cycles per phase.
    logic [3:0]  ist;
    int unsigned ecnt;
    logic        stall;
    logic        eng_flush;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ist       <= 4'b0000;
            ecnt      <= 0;
            eng_state <= 4'b0000;
        end else begin
            eng_state <= ist;
            if (eng_flush) begin
                ist <= 4'b0000;
            end else begin
                case (ist)
                    4'b0000: begin
                        if (control == 4'b0001) begin ist <= 4'b0001; ecnt <= 0; end
                        else if (control == 4'b0010) begin ist <= 4'b0010; ecnt <= 0; end
                    end
                    4'b0001, 4'b0010: begin
                        if (!(stall && ist == 4'b0010)) begin
                            if (ecnt == 4) ist <= 4'b1111;
                            else ecnt <= ecnt + 1;
                        end
                    end
                    4'b1111: if (control == 4'b1111) ist <= 4'b0000;
                    default: ist <= 4'b0000;
                endcase
            end
        end
    end

    typedef struct {
        logic [3:0] ctrl;
        logic [5:0] idx;
    } ctrl_exp_t;

    ctrl_exp_t  cq[$];
    logic [5:0] dq[$];
    ctrl_exp_t  ce;
    logic [5:0] de;
    logic [3:0] prev_ctrl = 4'b0000;

    // Monitor: every change of control and every done pulse pops an expectation.
    always @(negedge clk) begin
        if (rst) begin
            if (control !== prev_ctrl) begin
                if (cq.size() == 0) begin
                    flag_fail("ctrl_unexpected", 32'(control));
                end else begin
                    ce = cq.pop_front();
                    check("ctrl_seq", 32'(control), 32'(ce.ctrl));
                    check("ctrl_layer_idx", 32'(layer_idx), 32'(ce.idx));
                end
            end
            if (done) begin
                if (dq.size() == 0) begin
                    flag_fail("done_unexpected", 32'(layer_idx));
                end else begin
                    de = dq.pop_front();
                    check("done_layer_idx", 32'(layer_idx), 32'(de));
                    check("done_busy_low", 32'(busy), 32'd0);
                end
            end
        end
        prev_ctrl = control;
    end

    task automatic push_ctrl(input logic [3:0] c, input int i);
        ctrl_exp_t x;
        x.ctrl = c;
        x.idx  = 6'(i);
        cq.push_back(x);
    endtask

    task automatic push_run(input int n);
        for (int i = 0; i < n; i++) begin
            push_ctrl(4'b0001, i); push_ctrl(4'b0000, i); push_ctrl(4'b1111, i);
            push_ctrl(4'b0010, i); push_ctrl(4'b0000, i); push_ctrl(4'b1111, i);
        end
        if (n > 0) push_ctrl(4'b0000, n - 1);
        dq.push_back((n == 0) ? 6'd0 : 6'(n - 1));
    endtask

    task automatic do_start(input logic [5:0] n);
        @(posedge clk); #1;
        start = 1'b1;
        layer_num = n;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_layer_idx", 32'(layer_idx), 32'd0);
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk); #1;
            if (done) seen = 1;
        end
        if (!seen) flag_fail(name, 32'(budget));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: actual %0t required finish", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        bit seen;
        int c0, c1;
        rst = 1'b0; start = 1'b0; layer_num = '0; stall = 1'b0; eng_flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_control", 32'(control), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_layer_idx", 32'(layer_idx), 32'd0);
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        @(negedge clk) rst = 1'b1;

        // Single layer.
        push_run(1);
        do_start(6'd1);
        wait_done("single_done_wait", 300);
        repeat (5) @(posedge clk);

        // Three layers.
        push_run(3);
        do_start(6'd3);
        wait_done("three_done_wait", 600);
        repeat (5) @(posedge clk);

        // Zero layers: done two edges after start is driven, control idle.
        push_run(0);
        do_start(6'd0);
        check("zero_done_early", 32'(done), 32'd0);
        @(posedge clk); #1;
        check("zero_done", 32'(done), 32'd1);
        check("zero_control", 32'(control), 32'd0);
        @(posedge clk); #1;
        check("zero_done_pulse", 32'(done), 32'd0);
        check("zero_busy", 32'(busy), 32'd0);
        repeat (5) @(posedge clk);

        // Stalled compute phase: 16 cycles in C_WAIT after its control drop, then ERR.
        stall = 1'b1;
        push_ctrl(4'b0001, 0); push_ctrl(4'b0000, 0); push_ctrl(4'b1111, 0);
        push_ctrl(4'b0010, 0); push_ctrl(4'b0000, 0);
        do_start(6'd1);
        seen = 0; c0 = -1; c1 = -1;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(posedge clk); #1;
            if (c0 < 0 && phase == 2'b10 && control == 4'b0000) c0 = i;
            if (timeout_err) begin seen = 1; c1 = i; end
        end
        if (!seen) flag_fail("stall_timeout_wait", 32'd300);
        check("stall_wdog_cycles", 32'(c1 - c0), 32'd16);
        check("stall_control", 32'(control), 32'd0);
        check("stall_busy", 32'(busy), 32'd0);
        check("stall_phase", 32'(phase), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("stall_err_sticky", 32'(timeout_err), 32'd1);
        stall = 1'b0;
        eng_flush = 1'b1;
        @(posedge clk); #1;
        eng_flush = 1'b0;
        push_run(1);
        do_start(6'd1);
        check("restart_clears_err", 32'(timeout_err), 32'd0);
        wait_done("restart_done_wait", 300);
        repeat (5) @(posedge clk);

        // Start while busy is dropped.
        push_run(2);
        do_start(6'd2);
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk); #1;
            if (phase == 2'b01 && control == 4'b0000) seen = 1;
        end
        if (!seen) flag_fail("busy_pwait_wait", 32'd200);
        start = 1'b1;
        layer_num = 6'd5;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("busy_done_wait", 400);
        repeat (20) @(posedge clk);

        // Asynchronous reset in the second layer's compute ack.
        push_run(3);
        do_start(6'd3);
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(posedge clk); #1;
            if (layer_idx == 6'd1 && phase == 2'b10 && control == 4'b1111) seen = 1;
        end
        if (!seen) flag_fail("reset_cack_wait", 32'd400);
        #2;
        rst = 1'b0;
        cq.delete();
        dq.delete();
        #1;
        check("arst_control", 32'(control), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_layer_idx", 32'(layer_idx), 32'd0);
        check("arst_phase", 32'(phase), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_timeout_err", 32'(timeout_err), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        push_run(1);
        do_start(6'd1);
        wait_done("post_reset_done_wait", 300);
        repeat (10) @(posedge clk);

        check("ctrl_queue_drained", 32'(cq.size()), 32'd0);
        check("done_queue_drained", 32'(dq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
